inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 133 +++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: loadable instruction memory with a 1-cycle synchronous read,
// feeding a small in-order prefetch FIFO with valid/ready delivery, redirect and HALT handling.
module inst_fetch #(
    parameter int unsigned IMEM_AW    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [IMEM_AW-1:0] load_addr,
    input  logic [31:0]        load_data,
    input  logic               start,
    input  logic               redirect_en,
    input  logic [IMEM_AW-1:0] redirect_pc,
    input  logic               inst_ready,
    output logic [31:0]        inst,
    output logic               inst_valid,
    output logic [IMEM_AW-1:0] inst_pc,
    output logic               halted
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [2:0]  OP_HALT = 3'b111;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT_ST} state_t;

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [IMEM_AW-1:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    logic [31:0]        mem [2**IMEM_AW];
    logic [31:0]        mem_rdata_q;
    logic [31:0]        fifo_word [FIFO_DEPTH];
    logic [IMEM_AW-1:0] fifo_pc [FIFO_DEPTH];

    logic               mem_we;
    logic               issue;
    logic               push;
    logic               pop;
    logic               redirect_act;
    logic [CW:0]        occupancy;
    logic [31:0]        head_word;

    assign inst_valid = (count_q != '0);
    assign head_word  = fifo_word[rd_ptr_q];
    assign inst       = inst_valid ? head_word : '0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr_q] : '0;
    assign halted     = (state_q == HALT_ST);

    always_comb begin
        mem_we       = load_en && (state_q == IDLE || state_q == HALT_ST);
        redirect_act = redirect_en && (state_q == FETCH || state_q == DRAIN);
        pop          = inst_valid && inst_ready;
        // Reads already in flight count against capacity so the FIFO can never overflow.
        occupancy    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue        = (state_q == FETCH) && !redirect_act && (occupancy < (CW+1)'(FIFO_DEPTH));
        push         = (state_q == FETCH) && !redirect_act && inflight_q;

        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = pc_q;
        wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d       = count_q + CW'(push) - CW'(pop);

        case (state_q)
            IDLE, HALT_ST: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                if (issue) pc_d = pc_q + IMEM_AW'(1);
                if (push && mem_rdata_q[31:29] == OP_HALT) state_d = DRAIN;
            end
            DRAIN: begin
                // Nothing is pushed after the HALT word, so it is the last entry to leave.
                if (pop && head_word[31:29] == OP_HALT) state_d = HALT_ST;
            end
            default: state_d = IDLE;
        endcase

        if (redirect_act) begin
            state_d    = FETCH;
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage arrays carry no reset; occupancy and in-flight flags decide what is live.
    always_ff @(posedge clk) begin
        if (mem_we) mem[load_addr] <= load_data;
        if (issue)  mem_rdata_q    <= mem[pc_q];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr_q] <= mem_rdata_q;
            fifo_pc[wr_ptr_q]   <= inflight_pc_q;
        end
    end

endmodule
